// File: rtl/num_bcd_reg_n_if.sv
// -----------------------------------------------------------------------------
// num_bcd_reg_n_if
// Command/status bundle for the N-digit BCD counter register.
//   master : the controller driving tick/step/clear commands and serial ops
//   slave  : the counter register itself
// Signals:
//   slowclk, reg_inc, reg_dec     tick-qualified whole-value +1 / -1
//   reg_inc_dig, reg_clr_dig      per-digit bump / clear masks
//   op_valid, op_sub, op_val      serial add/sub request, operation, BCD operand
//   op_ready, op_done             handshake status
//   reg_val, reg_z, reg_wrap      value, zero flag, carry/borrow-out pulse
// -----------------------------------------------------------------------------
interface num_bcd_reg_n_if #(
  parameter int DIGITS = 3
);
  logic                  slowclk;
  logic                  reg_inc;
  logic                  reg_dec;
  logic [DIGITS-1:0]     reg_inc_dig;
  logic [DIGITS-1:0]     reg_clr_dig;
  logic                  op_valid;
  logic                  op_sub;
  logic [4*DIGITS-1:0]   op_val;
  logic                  op_ready;
  logic                  op_done;
  logic [4*DIGITS-1:0]   reg_val;
  logic                  reg_z;
  logic                  reg_wrap;

  modport master (
    output slowclk, reg_inc, reg_dec, reg_inc_dig, reg_clr_dig,
           op_valid, op_sub, op_val,
    input  op_ready, op_done, reg_val, reg_z, reg_wrap
  );

  modport slave (
    input  slowclk, reg_inc, reg_dec, reg_inc_dig, reg_clr_dig,
           op_valid, op_sub, op_val,
    output op_ready, op_done, reg_val, reg_z, reg_wrap
  );
endinterface

// File: rtl/num_bcd_reg_n.sv
// -----------------------------------------------------------------------------
// num_bcd_reg_n
// Parametrised N-digit BCD counter register. In IDLE it takes tick-qualified
// whole-value +1/-1, per-digit bump and per-digit clear. A serial BCD add or
// subtract of a captured operand processes one digit per clock (RUN), then
// spends one cycle in DONE where op_done pulses and saturation is applied.
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous active-high reset, clears all state
//   bus    num_bcd_reg_n_if slave modport (commands in, value/status out)
// Parameters:
//   DIGITS    number of BCD digits (>=1), digit 0 least significant
//   SATURATE  0 = wrap modulo 10^DIGITS, 1 = clamp at 0 / all-9s
// -----------------------------------------------------------------------------
module num_bcd_reg_n #(
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  num_bcd_reg_n_if.slave  bus
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One BCD digit add: returns {carry, digit}. Inputs are valid BCD digits.
  function automatic logic [4:0] bcd_add(input logic [3:0] a, input logic [3:0] b,
                                         input logic ci);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    if (s > 5'd9) bcd_add = {1'b1, s[3:0] - 4'd10};
    else          bcd_add = {1'b0, s[3:0]};
  endfunction

  // One BCD digit subtract: returns {borrow, digit}.
  function automatic logic [4:0] bcd_sub(input logic [3:0] a, input logic [3:0] b,
                                         input logic bi);
    logic [4:0] s;
    s = {1'b0, a} - {1'b0, b} - {4'd0, bi};
    if (s[4]) bcd_sub = {1'b1, s[3:0] + 4'd10};
    else      bcd_sub = {1'b0, s[3:0]};
  endfunction

  state_e          state_q;
  logic [W-1:0]    val_q;
  logic [W-1:0]    opd_q;
  logic            sub_q;
  logic            carry_q;
  logic [IDXW-1:0] idx_q;
  logic            wrap_q;
  logic            done_q;
  logic            ready_q;

  logic            tick_d;
  logic [W-1:0]    ripple_d;
  logic            ripple_c_d;
  logic [W-1:0]    step_val_d;
  logic [W-1:0]    bump_val_d;
  logic [W-1:0]    cmd_val_d;
  logic [W-1:0]    opd_clamp_d;
  logic [4:0]      ser_res_d;
  logic [W-1:0]    ser_val_d;
  int              cur_idx;

  // Whole-value +/-1 with ripple carry, saturating hold when out of range.
  always_comb begin
    logic       c;
    logic [4:0] r;
    ripple_d = val_q;
    c        = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.reg_inc) r = bcd_add(val_q[4*i +: 4], 4'd0, c);
      else             r = bcd_sub(val_q[4*i +: 4], 4'd0, c);
      ripple_d[4*i +: 4] = r[3:0];
      c = r[4];
    end
    ripple_c_d = c;
    step_val_d = (SATURATE && c) ? val_q : ripple_d;
  end

  // IDLE command merge: tick step or per-digit bump, then clears win per digit.
  always_comb begin
    tick_d = bus.slowclk & (bus.reg_inc ^ bus.reg_dec);
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.reg_inc_dig[i]) begin
        bump_val_d[4*i +: 4] = (val_q[4*i +: 4] >= 4'd9) ? 4'd0 : val_q[4*i +: 4] + 4'd1;
      end else begin
        bump_val_d[4*i +: 4] = val_q[4*i +: 4];
      end
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.reg_clr_dig[i]) cmd_val_d[4*i +: 4] = 4'd0;
      else if (tick_d)        cmd_val_d[4*i +: 4] = step_val_d[4*i +: 4];
      else                    cmd_val_d[4*i +: 4] = bump_val_d[4*i +: 4];
    end
  end

  // Operand capture clamps non-BCD digits to 9.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.op_val[4*i +: 4] > 4'd9) opd_clamp_d[4*i +: 4] = 4'd9;
      else                             opd_clamp_d[4*i +: 4] = bus.op_val[4*i +: 4];
    end
  end

  // Serial datapath: one digit of add/sub per cycle at the current index.
  always_comb begin
    cur_idx   = int'(idx_q);
    ser_val_d = val_q;
    if (sub_q) ser_res_d = bcd_sub(val_q[4*cur_idx +: 4], opd_q[4*cur_idx +: 4], carry_q);
    else       ser_res_d = bcd_add(val_q[4*cur_idx +: 4], opd_q[4*cur_idx +: 4], carry_q);
    ser_val_d[4*cur_idx +: 4] = ser_res_d[3:0];
  end

  // Control FSM with registered value and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      val_q   <= '0;
      opd_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.op_valid) begin
            opd_q   <= opd_clamp_d;
            sub_q   <= bus.op_sub;
            idx_q   <= '0;
            carry_q <= 1'b0;
            wrap_q  <= 1'b0;
            ready_q <= 1'b0;
            state_q <= ST_RUN;
          end else begin
            val_q  <= cmd_val_d;
            wrap_q <= tick_d & ripple_c_d;
          end
        end
        ST_RUN: begin
          val_q   <= ser_val_d;
          carry_q <= ser_res_d[4];
          if (idx_q == IDXW'(DIGITS - 1)) begin
            // Carry out of the top digit shows as reg_wrap during DONE.
            wrap_q  <= ser_res_d[4];
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            wrap_q <= 1'b0;
            idx_q  <= idx_q + IDXW'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          wrap_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
          if (SATURATE && carry_q) begin
            val_q <= sub_q ? '0 : ALL9;
          end else begin
            val_q <= val_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          wrap_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.reg_val  = val_q;
  assign bus.reg_z    = (val_q == '0);
  assign bus.reg_wrap = wrap_q;
  assign bus.op_done  = done_q;
  assign bus.op_ready = ready_q;

endmodule
